branch_target_buffer: RTL
=========================

# branch_target_buffer

Direct-mapped branch target buffer with saturating-counter direction prediction, sitting in the fetch stage of the pipelined datapath. It supplies a predicted next PC in the same cycle as the instruction fetch. It is trained by branch and jump resolution from the execute stage. Entry count and counter width are parametrised, and it keeps branch and mispredict statistics for performance runs.

## Interface
- ENTRIES, 16, number of table entries; power of two, 2..256
- CTR_BITS, 2, width of each direction counter; 1..4
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- lk_pc  in  32  fetch PC to look up
- lk_hit  out  1  valid entry with matching tag at lk_pc
- lk_taken  out  1  lk_hit && counter MSB set
- lk_next_pc  out  32  lk_taken ? stored target : lk_pc+4
- upd_en  in  1  resolved control-flow instruction in EX this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target, meaningful when upd_taken
- upd_mispredict  in  1  datapath flushed for this resolution
- inv  in  1  invalidate all entries
- stat_branches  out  32  count of upd_en cycles
- stat_mispredicts  out  32  count of upd_en && upd_mispredict cycles

## Operation
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2]. Tag = pc[31:IDX+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target (32), and ctr (CTR_BITS).
- Lookup is purely combinational from the registered table.
- Update is applied at the clock edge when upd_en is high. The entry at upd_pc's index is handled as follows:
  - Hit, taken: ctr increments, saturating at all-ones; target := upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target is unchanged.
  - Miss, taken: the entry is allocated or overwritten, including an aliasing valid entry. valid := 1, tag := new tag, target := upd_target, ctr := weakly taken (MSB=1, other bits 0).
  - Miss, not taken: no change.
- CTR_BITS=1 degenerates to last-outcome prediction.
- inv clears every valid bit at the clock edge. ctr, tag and target are left unchanged.
- Statistics counters saturate at 0xFFFFFFFF and never wrap.
- Statistics are updated on upd_en regardless of inv.

## Timing
- Reset values:
  - All valid bits are 0.
  - All ctr, tag and target fields are 0.
  - Both statistics counters are 0.
  - Consequently lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+4.
- Lookup latency is zero cycles. An update becomes visible to lookup on the cycle after the edge that applies it.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- inv and upd_en in the same cycle: inv wins. The table is all-invalid after the edge, and the update's allocation is discarded.
- Reset asserted mid-operation clears the table and statistics immediately and asynchronously. The table is usable on the first edge after release.
- No stall input. The datapath holds lk_pc stable while stalled; the datapath gates upd_en to one pulse per resolved instruction.

## Structure
- word_t comes from cpu_types_pkg.
- btb_entry_t (valid, tag, target, ctr) goes in cpu_types_pkg, parametrised via localparams derived in the module.
- Sub-module sat_counter #(W): combinational next-value logic taking cur, inc and dec, producing the next value; reused per update.
- Table storage is flip-flops (array of btb_entry_t), not SRAM.

## Test plan
All scenarios use ENTRIES=16, CTR_BITS=2.
- Reset, then lk_pc=0x40 -> lk_hit=0, lk_taken=0, lk_next_pc=0x44, both stats 0.
- upd_en, upd_pc=0x40, upd_taken=1, upd_target=0x100 -> next cycle, lk_pc=0x40 gives lk_hit=1, lk_taken=1 (ctr=2), lk_next_pc=0x100; stat_branches=1.
- Following on, three not-taken updates to 0x40 -> ctr goes 1, 0, 0. lk_taken=0 after the first; lk_next_pc=0x44; lk_hit stays 1.
- Entry valid for 0x40, then a taken update at 0x80 (same index 0, tag 2) with target 0x200 -> lookup 0x40 misses; lookup 0x80 hits with lk_next_pc=0x200.
- Lookup 0x40 in the same cycle as the first taken update to 0x40 -> lk_hit=0 that cycle and 1 the next.
- inv with a simultaneous taken update -> both miss afterwards.
- Three updates with upd_mispredict=1 and two with 0 -> stat_branches=5, stat_mispredicts=3.
- nRST pulsed mid-sequence -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word and the branch target buffer entry layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Entry fields are sized for the widest legal configuration (ENTRIES=2, CTR_BITS=4).
  // Narrower configurations keep the unused upper bits at zero.
  localparam int BTB_TAG_MAX = 29;
  localparam int BTB_CTR_MAX = 4;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    word_t                  target;
    logic [BTB_CTR_MAX-1:0] ctr;
  } btb_entry_t;

  function automatic word_t sat_incr(input word_t v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down counter next-value logic; holds when both or neither of inc/dec are set.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != {W{1'b1}})) begin
      nxt = cur + W'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counters and
// branch/mispredict statistics. Lookup is combinational from the registered table.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t lk_pc,
  output logic  lk_hit,
  output logic  lk_taken,
  output word_t lk_next_pc,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  logic  upd_taken,
  input  word_t upd_target,
  input  logic  upd_mispredict,
  input  logic  inv,
  output word_t stat_branches,
  output word_t stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [BTB_CTR_MAX-1:0] CTR_WEAK_TAKEN = BTB_CTR_MAX'(1 << (CTR_BITS - 1));

  btb_entry_t table_q [ENTRIES];

  // Lookup path
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;

  assign lk_idx     = lk_pc[IDX+1:2];
  assign lk_tag     = lk_pc[31:IDX+2];
  assign lk_entry   = table_q[lk_idx];
  assign lk_hit     = lk_entry.valid && (lk_entry.tag == BTB_TAG_MAX'(lk_tag));
  assign lk_taken   = lk_hit && lk_entry.ctr[CTR_BITS-1];
  assign lk_next_pc = lk_taken ? lk_entry.target : lk_pc + 32'd4;

  // Update path: upd_en is a single-cycle pulse per resolved instruction, no handshake.
  logic [IDX-1:0]      upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  btb_entry_t          upd_old;
  btb_entry_t          upd_new;
  logic                upd_hit;
  logic                upd_write;
  logic [CTR_BITS-1:0] ctr_nxt;

  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[31:IDX+2];
  assign upd_old = table_q[upd_idx];
  assign upd_hit = upd_old.valid && (upd_old.tag == BTB_TAG_MAX'(upd_tag));

  sat_counter #(.W(CTR_BITS)) u_ctr (
    .cur (upd_old.ctr[CTR_BITS-1:0]),
    .inc (upd_hit && upd_taken),
    .dec (upd_hit && !upd_taken),
    .nxt (ctr_nxt)
  );

  always_comb begin
    upd_new   = upd_old;
    upd_write = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        upd_write   = 1'b1;
        upd_new.ctr = BTB_CTR_MAX'(ctr_nxt);
        if (upd_taken) begin
          upd_new.target = upd_target;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever occupies the slot, aliasing entries included.
        upd_write      = 1'b1;
        upd_new.valid  = 1'b1;
        upd_new.tag    = BTB_TAG_MAX'(upd_tag);
        upd_new.target = upd_target;
        upd_new.ctr    = CTR_WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      // Invalidate takes priority and discards a same-cycle allocation.
      if (inv) begin
        for (int i = 0; i < ENTRIES; i++) begin
          table_q[i].valid <= 1'b0;
        end
      end else if (upd_write) begin
        table_q[upd_idx] <= upd_new;
      end
      if (upd_en) begin
        stat_branches <= sat_incr(stat_branches);
        if (upd_mispredict) begin
          stat_mispredicts <= sat_incr(stat_mispredicts);
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0], lk_entry.ctr, upd_old.ctr};

endmodule
